// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The FSM uses two state bits. The encoding 2'd3 is unused and recovers to IDLE.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell that the serial adder drives once per clock.
// Latency: combinational, zero cycles.
// Backpressure: none; the outputs follow the inputs continuously.
//
// Ports: a, b, c  - the two addend bits and the carry-in bit
//        sum      - a ^ b ^ c
//        carry    - majority(a, b, c)
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell is reused LSB-first across WIDTH clocks.
// Latency: start is accepted at edge k and done pulses in the cycle after edge k+WIDTH.
// Backpressure: start is ignored while busy; there is no queueing. Back-to-back use needs WIDTH+2 cycles.
//
// Ports: clk, rst (synchronous, active-high)
//        start, a, b, cin - request and operands, sampled only in IDLE
//        busy             - high in SHIFT and DONE
//        done             - one-cycle pulse while sum/cout are valid
//        sum, cout        - result, held until overwritten by the next add
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic cell_sum;
    logic cell_carry;

    fa_cell u_fa_cell (
        .a     (shift_a[0]),
        .b     (shift_b[0]),
        .c     (carry),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            shift_a <= '0;
            shift_b <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // sum/cout are left alone so the last result stays readable.
                    if (start) begin
                        shift_a <= a;
                        shift_b <= b;
                        carry   <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Result bits enter at the MSB end. After WIDTH shifts,
                    // the first bit computed (the LSB) lands in sum[0].
                    carry   <= cell_carry;
                    sum     <= {cell_sum, sum[WIDTH-1:1]};
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        cout  <= cell_carry;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. It uses WIDTH=8 and WIDTH=3 instances on one clock.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_serial_adder;

    typedef struct {
        int v;   // expected {cout,sum}
        int e;   // edge number at which start was accepted
    } sb_t;

    logic clk;
    int   cyc;

    logic       rst8, start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       rst3, start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    int total;
    int bad;
    int ndone8;
    int ndone3;
    logic prev8;
    logic prev3;
    sb_t  q8[$];
    sb_t  q3[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitors: each done pulse pops one expected result.
    always @(negedge clk) begin
        sb_t s;
        if (done8) begin
            ndone8++;
            check("done8_width", prev8, 1'b0);
            check("q8_nonempty", q8.size() != 0, 1'b1);
            if (q8.size() != 0) begin
                s = q8.pop_front();
                check("sum8", {cout8, sum8}, s.v);
                check("lat8", cyc - s.e, 8);
            end
        end
        if (done3) begin
            ndone3++;
            check("done3_width", prev3, 1'b0);
            check("q3_nonempty", q3.size() != 0, 1'b1);
            if (q3.size() != 0) begin
                s = q3.pop_front();
                check("sum3", {cout3, sum3}, s.v);
                check("lat3", cyc - s.e, 3);
            end
        end
        prev8 = done8;
        prev3 = done3;
    end

    // One complete add on the 8-bit instance. The task is called at a negedge
    // and returns at the first negedge where busy has dropped.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int  n;
        sb_t s;
        n = 0;
        while (busy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle8_wait", busy8, 1'b0);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        s.v = int'(a) + int'(b) + int'(c);
        s.e = cyc + 1;
        q8.push_back(s);
        @(negedge clk);
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
        n = 0;
        while (busy8 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy8_len", n, 9);
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c);
        int  n;
        sb_t s;
        n = 0;
        while (busy3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle3_wait", busy3, 1'b0);
        a3 = a; b3 = b; cin3 = c; start3 = 1'b1;
        s.v = int'(a) + int'(b) + int'(c);
        s.e = cyc + 1;
        q3.push_back(s);
        @(negedge clk);
        start3 = 1'b0;
        a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
        n = 0;
        while (busy3 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy3_len", n, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        sb_t s;
        total = 0; bad = 0; ndone8 = 0; ndone3 = 0;
        prev8 = 1'b0; prev3 = 1'b0;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst3 = 1'b1; start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst3 = 1'b0;

        // Reset state
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_sum", sum8, 8'h00);
        check("rst_cout", cout8, 1'b0);
        check("rst_busy3", busy3, 1'b0);
        @(negedge clk);

        // Basic add: 5A + 25 + 1 = 80
        op8(8'h5A, 8'h25, 1'b1);
        check("basic_sum_hold", sum8, 8'h80);

        // Overflow: FF + 01 = 1_00. The result must hold while idle.
        op8(8'hFF, 8'h01, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("ovf_hold_sum", sum8, 8'h00);
            check("ovf_hold_cout", cout8, 1'b1);
        end

        // A start asserted while busy is ignored.
        d0 = ndone8;
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        s.v = 7; s.e = cyc + 1;
        q8.push_back(s);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 40) begin
            n++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("ignore_one_done", ndone8 - d0, 1);
        check("ignore_sum", sum8, 8'h07);
        op8(8'hF0, 8'h0F, 1'b0);
        check("after_ignore_sum", sum8, 8'hFF);

        // Reset in the middle of an AA + 55 add.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        s.v = 9'h0FF; s.e = cyc + 1;
        q8.push_back(s);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        q8.delete();
        check("midrst_busy", busy8, 1'b0);
        check("midrst_done", done8, 1'b0);
        check("midrst_sum", sum8, 8'h00);
        check("midrst_cout", cout8, 1'b0);
        d0 = ndone8;
        repeat (12) @(negedge clk);
        check("midrst_no_done", ndone8 - d0, 0);
        op8(8'h01, 8'h01, 1'b0);
        check("midrst_after_sum", sum8, 8'h02);

        // rst and start on the same edge: reset wins.
        d0 = ndone8;
        a8 = 8'h11; b8 = 8'h22; rst8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0; start8 = 1'b0;
        check("rst_start_busy", busy8, 1'b0);
        @(negedge clk);
        check("rst_start_busy2", busy8, 1'b0);
        repeat (12) @(negedge clk);
        check("rst_start_no_done", ndone8 - d0, 0);

        // Random regression on both widths at the same time.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    op8(8'($urandom), 8'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    op3(3'($urandom), 3'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join

        repeat (4) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q3_drained", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
